cram_frame_loader: RTL
======================

// Module: cram_frame_loader
// PURPOSE
//  Sequences loading of the configuration SRAM (CRAM) array behind the LVS transistor/resistor primitives.
//  Accepts config bytes over a valid/ready stream and serialises them MSB-first into the column shift chain.
//  After each full frame it pulses the row word line to commit the frame, then advances the row address.
//  Sits between the SPI/host bitstream front end and the CRAM column/row drivers.
// PARAMETERS
//  FRAME_BITS  16  bits per CRAM row frame; must be a multiple of 8 and >= 8
//  NUM_ROWS    8   number of CRAM rows (frames) per load; >= 1
//  ADDR_W      3   ROW_ADDR width; 2**ADDR_W >= NUM_ROWS
//  WL_PULSE    2   cycles ROW_WL is held high per frame commit; >= 1
// PORTS
//  CLK        in   1       single clock; all logic rising-edge
//  RST        in   1       synchronous, active-high reset
//  START      in   1       single-cycle request to begin a load
//  IN_DATA    in   8       config byte
//  IN_VALID   in   1       IN_DATA valid
//  IN_READY   out  1       loader can accept IN_DATA this cycle
//  COL_SDI    out  1       serial data into column shift chain
//  COL_SHIFT  out  1       shift enable for column chain; one bit per cycle
//  ROW_ADDR   out  ADDR_W  row currently being filled/committed
//  ROW_WL     out  1       word-line strobe committing column chain into ROW_ADDR
//  BUSY       out  1       high from START acceptance until DONE state
//  DONE       out  1       load complete; held until next START or RST
//  ERR        out  1       sticky: START received while BUSY
// BEHAVIOUR
//  Reset: state=IDLE; IN_READY, COL_SDI, COL_SHIFT, ROW_WL, BUSY, DONE, ERR = 0; ROW_ADDR = 0;
//  byte/bit/pulse counters = 0. RST mid-load aborts immediately; no further ROW_WL; partial frame discarded.
//  States: IDLE, LOAD, SHIFT, WRITE, FIN.
//  IDLE: IN_READY=0. START -> LOAD next cycle; ROW_ADDR=0, frame bit count=0, DONE cleared, BUSY=1.
//  LOAD: IN_READY=1 (combinational from state). IN_VALID&IN_READY captures byte -> SHIFT. No capture otherwise.
//  SHIFT: exactly 8 cycles, COL_SHIFT=1, COL_SDI=byte[7-i] for cycle i (registered outputs, valid same cycle).
//   IN_READY=0. After 8th bit: frame count += 8; if count == FRAME_BITS -> WRITE (count reset to 0), else -> LOAD.
//  WRITE: ROW_WL=1 for WL_PULSE consecutive cycles; COL_SHIFT=0; ROW_ADDR stable throughout and for the
//   cycle before/after. Then: ROW_ADDR==NUM_ROWS-1 -> FIN; else ROW_ADDR+1 -> LOAD.
//  FIN: DONE=1, BUSY=0, IN_READY=0; ROW_ADDR holds last row. START -> as from IDLE (DONE drops next cycle).
//  Bytes per frame = FRAME_BITS/8; total bytes = NUM_ROWS*FRAME_BITS/8. Min cycles per byte = 9 (1 LOAD + 8 SHIFT).
//  START while BUSY (LOAD/SHIFT/WRITE): ignored for sequencing, ERR set; ERR clears only on RST.
//  START and RST same cycle: RST wins. IN_VALID outside LOAD: ignored, data not consumed.
//  Extra bytes after FIN are never accepted (IN_READY=0). COL_SHIFT and ROW_WL are never high together.
// TESTING
//  1 Reset: RST=1 3 cycles with IN_VALID=1 -> all outputs 0, no COL_SHIFT/ROW_WL, ROW_ADDR=0.
//  2 Full load defaults: START, stream 16 bytes 0xA5,0x3C,... with IN_VALID always 1 -> 8 ROW_WL pulses of
//    2 cycles, ROW_ADDR 0..7, COL_SDI per frame = bits of both bytes MSB-first (0xA5 -> 1,0,1,0,0,1,0,1), DONE=1.
//  3 Back-pressure: IN_VALID toggles 1/0 randomly -> same COL_SDI sequence and ROW_WL count as test 2.
//  4 START while BUSY at row 3 -> ERR=1 sticky, load continues to DONE; ROW_ADDR unaffected.
//  5 RST asserted during SHIFT of row 5 -> next cycle IDLE, no ROW_WL; new START reloads from ROW_ADDR=0.
//  6 FIN then START again -> DONE drops, second complete load of 16 bytes succeeds; params NUM_ROWS=1,
//    FRAME_BITS=8 -> 1 byte, 1 WL pulse, DONE after 8+1+WL_PULSE cycles.

Source files
------------

// File: rtl/cram_frame_loader_if.sv
// Byte stream carrying configuration data from the bitstream front end into the CRAM frame loader.
// The host drives data/valid; the loader answers with ready.
interface cram_frame_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cram_frame_loader.sv
// CRAM frame loader: serialises config bytes MSB-first into the column chain, then strobes the row
// word line once per full frame and steps through NUM_ROWS rows.
module cram_frame_loader #(
    parameter int FRAME_BITS = 16,
    parameter int NUM_ROWS   = 8,
    parameter int ADDR_W     = 3,
    parameter int WL_PULSE   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    cram_frame_loader_if.slave     cfg,
    output logic                   col_sdi,
    output logic                   col_shift,
    output logic [ADDR_W-1:0]      row_addr,
    output logic                   row_wl,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int FCW = $clog2(FRAME_BITS + 1);
    localparam int PCW = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;
    localparam logic [FCW-1:0]    FRAME_LAST = FCW'(FRAME_BITS - 8);
    localparam logic [FCW-1:0]    BYTE_BITS  = FCW'(8);
    localparam logic [PCW-1:0]    PULSE_LAST = PCW'(WL_PULSE - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, WRITE, FIN} state_t;

    state_t              state_reg;
    logic [7:0]          byte_reg;
    logic [2:0]          bit_reg;
    logic [FCW-1:0]      frame_cnt_reg;
    logic [PCW-1:0]      pulse_cnt_reg;
    logic                adv_pending_reg;
    logic                col_sdi_reg;
    logic                col_shift_reg;
    logic [ADDR_W-1:0]   row_addr_reg;
    logic                row_wl_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                err_reg;
    logic [7:0]          msb_first;

    // msb_first[i] is the bit presented on shift cycle i of the captured byte.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_order
            assign msb_first[gi] = byte_reg[7-gi];
        end
    endgenerate

    assign cfg.in_ready = (state_reg == LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            byte_reg        <= '0;
            bit_reg         <= '0;
            frame_cnt_reg   <= '0;
            pulse_cnt_reg   <= '0;
            adv_pending_reg <= 1'b0;
            col_sdi_reg     <= 1'b0;
            col_shift_reg   <= 1'b0;
            row_addr_reg    <= '0;
            row_wl_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            if (start && busy_reg) begin
                err_reg <= 1'b1;
            end
            // Row advance is deferred one cycle so the address stays put the cycle after the strobe.
            if (adv_pending_reg) begin
                row_addr_reg    <= row_addr_reg + ADDR_W'(1);
                adv_pending_reg <= 1'b0;
            end

            case (state_reg)
                IDLE, FIN: begin
                    if (start) begin
                        state_reg     <= LOAD;
                        row_addr_reg  <= '0;
                        frame_cnt_reg <= '0;
                        done_reg      <= 1'b0;
                        busy_reg      <= 1'b1;
                    end
                end

                LOAD: begin
                    if (cfg.in_valid) begin
                        byte_reg      <= cfg.in_data;
                        bit_reg       <= '0;
                        col_sdi_reg   <= cfg.in_data[7];
                        col_shift_reg <= 1'b1;
                        state_reg     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (bit_reg == 3'd7) begin
                        col_shift_reg <= 1'b0;
                        col_sdi_reg   <= 1'b0;
                        if (frame_cnt_reg == FRAME_LAST) begin
                            frame_cnt_reg <= '0;
                            pulse_cnt_reg <= '0;
                            row_wl_reg    <= 1'b1;
                            state_reg     <= WRITE;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + BYTE_BITS;
                            state_reg     <= LOAD;
                        end
                    end else begin
                        bit_reg     <= bit_reg + 3'd1;
                        col_sdi_reg <= msb_first[bit_reg + 3'd1];
                    end
                end

                WRITE: begin
                    if (pulse_cnt_reg == PULSE_LAST) begin
                        row_wl_reg <= 1'b0;
                        if (row_addr_reg == ROW_LAST) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= FIN;
                        end else begin
                            adv_pending_reg <= 1'b1;
                            state_reg       <= LOAD;
                        end
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg + PCW'(1);
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign col_sdi   = col_sdi_reg;
    assign col_shift = col_shift_reg;
    assign row_addr  = row_addr_reg;
    assign row_wl    = row_wl_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
endmodule
